// File: rtl/simd_pkg.sv
// simd_pkg: opcode/fn codes, burst-reduction legality and saturating clamp helpers shared by the SIMD array.
package simd_pkg;
    localparam logic [3:0] OP_ARITH = 4'd0;
    localparam logic [3:0] OP_CMP = 4'd1;
    localparam logic [3:0] OP_UNARY = 4'd2;
    localparam logic [3:0] FN_ADD = 4'd0;
    localparam logic [3:0] FN_SUB = 4'd1;
    localparam logic [3:0] FN_MUL = 4'd2;
    localparam logic [3:0] FN_MAC = 4'd3;
    localparam logic [3:0] FN_MAX = 4'd0;
    localparam logic [3:0] FN_MIN = 4'd1;
    localparam logic [3:0] FN_EQ = 4'd2;
    localparam logic [3:0] FN_GT = 4'd3;
    localparam logic [3:0] FN_RELU = 4'd0;
    localparam logic [3:0] FN_ABS = 4'd1;
    localparam logic [3:0] FN_NEG = 4'd2;
    // Wide enough to hold any lane result before clamping for lane widths up to 64 bits.
    localparam int XW = 130;
    typedef logic signed [XW-1:0] wide_t;

    function automatic wide_t sat_clamp(input wide_t v, input int w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        return v > hi ? hi : v < lo ? lo : v;
    endfunction

    function automatic logic sat_hit(input wide_t v, input int w);
        return sat_clamp(v, w) != v;
    endfunction

    function automatic logic acc_legal(input logic [3:0] op, input logic [3:0] f);
        return (op == OP_ARITH && (f == FN_ADD || f == FN_MAC)) || (op == OP_CMP && (f == FN_MAX || f == FN_MIN));
    endfunction
endpackage

// File: rtl/simd_lane_alu.sv
// simd_lane_alu: one lane -- S1 operand/product register, S2 saturating ALU, burst accumulator and output register.
module simd_lane_alu
    import simd_pkg::*;
#(
    parameter int W = 32,
    parameter int OB = 4,
    parameter int FB = 4,
    parameter int SB = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          adv,
    input  logic [W-1:0]  a_in,
    input  logic [W-1:0]  b_in,
    input  logic [SB-1:0] shift,
    input  logic          v1,
    input  logic [OB-1:0] op,
    input  logic [FB-1:0] fn,
    input  logic          acc,
    input  logic          start,
    input  logic          last,
    output logic [W-1:0]  data_out,
    output logic          sat_out
);
    localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

    logic signed [W-1:0] a1, b1, acc_val, ident, xa;
    logic signed [2*W-1:0] p1, prod;
    logic acc_sat, hit, sat_now;
    logic [W-1:0] res;
    wide_t x, b, p, v;
    int shamt;

    always_comb begin
        shamt = int'(shift) > 2*W-1 ? 2*W-1 : int'(shift);
        prod = (2*W)'($signed(a_in)) * (2*W)'($signed(b_in));
    end

    // Operand A is the accumulator during a reduction; the first beat of a burst sees the op's identity.
    always_comb begin
        ident = op == OP_CMP ? (fn == FN_MIN ? SMAX : SMIN) : {W{1'b0}};
        xa = !acc ? a1 : start ? ident : acc_val;
        x = wide_t'(xa);
        b = wide_t'(b1);
        p = wide_t'(p1);
        case ({op, fn})
            {OP_ARITH, FN_ADD}:  v = x + b;
            {OP_ARITH, FN_SUB}:  v = x - b;
            {OP_ARITH, FN_MUL}:  v = p;
            {OP_ARITH, FN_MAC}:  v = x + p;
            {OP_CMP, FN_MAX}:    v = x > b ? x : b;
            {OP_CMP, FN_MIN}:    v = x < b ? x : b;
            {OP_CMP, FN_EQ}:     v = wide_t'(x == b);
            {OP_CMP, FN_GT}:     v = wide_t'(x > b);
            {OP_UNARY, FN_RELU}: v = x[XW-1] ? wide_t'(0) : x;
            {OP_UNARY, FN_ABS}:  v = x[XW-1] ? -x : x;
            {OP_UNARY, FN_NEG}:  v = -x;
            default:             v = wide_t'(0);
        endcase
        res = W'(sat_clamp(v, W));
        hit = sat_hit(v, W);
        sat_now = hit | (acc && !start && acc_sat);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a1 <= '0;
            b1 <= '0;
            p1 <= '0;
            acc_val <= '0;
            acc_sat <= 1'b0;
            data_out <= '0;
            sat_out <= 1'b0;
        end else if (adv) begin
            a1 <= a_in;
            b1 <= b_in;
            p1 <= prod >>> shamt;
            if (v1 && acc) begin
                acc_val <= res;
                acc_sat <= sat_now;
            end
            if (v1 && (!acc || last)) begin
                data_out <= res;
                sat_out <= sat_now;
            end
        end
    end
endmodule

// File: rtl/simd_compute_array.sv
// simd_compute_array: NUM_LANES-wide two-stage saturating SIMD ALU with valid/ready streaming
// and per-lane burst reduction; lanes share one opcode/fn per beat.
module simd_compute_array
    import simd_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int DATA_WIDTH = 32,
    parameter int OPCODE_BITS = 4,
    parameter int FUNCTION_BITS = 4,
    parameter int SHIFT_BITS = 6
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_last,
    input  logic [OPCODE_BITS-1:0]          opcode,
    input  logic [FUNCTION_BITS-1:0]        fn,
    input  logic                            acc_en,
    input  logic [SHIFT_BITS-1:0]           mul_shift,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] data_in0,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] data_in1,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            out_last,
    output logic [NUM_LANES*DATA_WIDTH-1:0] data_out,
    output logic [NUM_LANES-1:0]            out_sat
);
    logic adv, accept, first, burst_cont, acc_go;
    logic v1, acc1, start1, last1;
    logic [OPCODE_BITS-1:0] op1, lat_op, op_eff;
    logic [FUNCTION_BITS-1:0] fn1, lat_fn, fn_eff;

    assign adv = !(out_valid && !out_ready);
    assign in_ready = adv;
    assign accept = in_valid && adv;

    // Mid-burst beats reuse the op latched on the burst's first beat.
    always_comb begin
        burst_cont = acc_en && !first;
        acc_go = burst_cont || (acc_en && acc_legal(opcode, fn));
        op_eff = burst_cont ? lat_op : opcode;
        fn_eff = burst_cont ? lat_fn : fn;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1 <= 1'b0;
            acc1 <= 1'b0;
            start1 <= 1'b0;
            last1 <= 1'b0;
            op1 <= '0;
            fn1 <= '0;
            lat_op <= '0;
            lat_fn <= '0;
            first <= 1'b1;
            out_valid <= 1'b0;
            out_last <= 1'b0;
        end else if (adv) begin
            v1 <= in_valid;
            acc1 <= acc_go;
            start1 <= acc_go && first;
            last1 <= in_last;
            op1 <= op_eff;
            fn1 <= fn_eff;
            if (accept && acc_go) begin
                first <= in_last;
                if (first) begin
                    lat_op <= opcode;
                    lat_fn <= fn;
                end
            end
            out_valid <= v1 && (!acc1 || last1);
            out_last <= v1 && last1;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        simd_lane_alu #(
            .W(DATA_WIDTH),
            .OB(OPCODE_BITS),
            .FB(FUNCTION_BITS),
            .SB(SHIFT_BITS)
        ) u_alu (
            .clk(clk),
            .reset(reset),
            .adv(adv),
            .a_in(data_in0[i*DATA_WIDTH +: DATA_WIDTH]),
            .b_in(data_in1[i*DATA_WIDTH +: DATA_WIDTH]),
            .shift(mul_shift),
            .v1(v1),
            .op(op1),
            .fn(fn1),
            .acc(acc1),
            .start(start1),
            .last(last1),
            .data_out(data_out[i*DATA_WIDTH +: DATA_WIDTH]),
            .sat_out(out_sat[i])
        );
    end
endmodule
